// File: rtl/sfx_sequencer_if.sv
// sfx_sequencer_if
// Bundles the request side and the tone-generator side of the sound-effect
// scheduler.
//
// Ports / signals (N_REQ requesters, index 0 = highest priority):
//   req        [N_REQ]     one-cycle request pulses from game logic
//   req_base   [6*N_REQ]   first note code of each effect
//   req_len    [4*N_REQ]   step count of each effect (0 behaves as 1)
//   req_delta  [3*N_REQ]   signed per-step note increment (-4..+3)
//   mute                   forces note to 0 without disturbing sequencing
//   note       [6]         note code to the tone generator, 0 = silence
//   busy                   effect playing or in its trailing gap
//   active_id  [ID_W]      index of the effect currently loaded
//   grant      [N_REQ]     one-cycle pulse when an effect is loaded
//   done                   one-cycle pulse when an effect completes normally
//
// master: the side that issues requests and consumes the note stream.
// slave : the sequencer itself.
interface sfx_sequencer_if #(
    parameter int N_REQ = 4
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]   req;
    logic [6*N_REQ-1:0] req_base;
    logic [4*N_REQ-1:0] req_len;
    logic [3*N_REQ-1:0] req_delta;
    logic               mute;
    logic [5:0]         note;
    logic               busy;
    logic [ID_W-1:0]    active_id;
    logic [N_REQ-1:0]   grant;
    logic               done;

    modport master (
        output req, req_base, req_len, req_delta, mute,
        input  note, busy, active_id, grant, done
    );

    modport slave (
        input  req, req_base, req_len, req_delta, mute,
        output note, busy, active_id, grant, done
    );
endinterface

// File: rtl/sfx_sequencer.sv
// sfx_sequencer
// Schedules one-shot sound effects for the speaker tone generator. Requests
// from N_REQ sources are latched as pending, arbitrated by fixed priority
// (index 0 highest), and the winner is played as a stepped arpeggio of note
// codes. A strictly higher-priority request preempts a playing effect on the
// next tick. Each completed effect is followed by a one-tick silent gap.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    sfx_sequencer_if.slave (requests in, note/status out)
//
// Parameters:
//   N_REQ       number of requesters
//   TICK_DIV    clk cycles per tick (>= 2)
//   STEP_TICKS  ticks per arpeggio step (>= 1)
module sfx_sequencer #(
    parameter int N_REQ      = 4,
    parameter int TICK_DIV   = 250000,
    parameter int STEP_TICKS = 25
) (
    input  logic           clk,
    input  logic           rst_n,
    sfx_sequencer_if.slave bus
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW   = $clog2(TICK_DIV);
    localparam int SW   = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [N_REQ-1:0]  pend_q;
    logic [PW-1:0]     presc_q;
    logic [SW-1:0]     step_cnt_q;
    logic [3:0]        steps_left_q;
    logic [5:0]        note_q;
    logic signed [2:0] delta_q;
    logic [ID_W-1:0]   active_id_q;
    logic [N_REQ-1:0]  grant_q;
    logic              done_q;

    // Arbitration results
    logic              any_pend;
    logic [ID_W-1:0]   win;
    logic [N_REQ-1:0]  win_oh;
    logic [5:0]        sel_base;
    logic [3:0]        sel_len;
    logic signed [2:0] sel_delta;
    logic              preempt;
    logic              tick;

    // Control decode
    logic              do_load;
    logic              do_step;
    logic              step_end;
    logic              last_step;
    logic [N_REQ-1:0]  load_oh;

    // Advance a note by a signed delta, saturating to 1..63. A note of 0 is
    // a rest and stays a rest for the whole effect.
    function automatic logic [5:0] note_step(input logic [5:0]        cur,
                                             input logic signed [2:0] d);
        logic signed [7:0] nx;
        nx = $signed({2'b00, cur}) + $signed({{5{d[2]}}, d});
        if (cur == 6'd0) begin
            return 6'd0;
        end
        if (nx < 8'sd1) begin
            return 6'd1;
        end
        if (nx > 8'sd63) begin
            return 6'd63;
        end
        return nx[5:0];
    endfunction

    // Lowest set pending index wins; its effect parameters are muxed out so
    // they can be captured at the load edge.
    always_comb begin
        any_pend  = |pend_q;
        win       = '0;
        win_oh    = '0;
        sel_base  = '0;
        sel_len   = '0;
        sel_delta = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                win       = ID_W'(i);
                win_oh    = N_REQ'(1) << i;
                sel_base  = bus.req_base[6*i +: 6];
                sel_len   = bus.req_len[4*i +: 4];
                sel_delta = bus.req_delta[3*i +: 3];
            end
        end
    end

    assign tick    = (presc_q == PW'(TICK_DIV - 1));
    assign preempt = any_pend && (win < active_id_q);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (do_load)   state_d = S_PLAY;
            S_PLAY:  if (last_step) state_d = S_GAP;
            S_GAP:   if (tick)      state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM control outputs. In PLAY a tick is consumed either by a preempting
    // load or by step processing, never both.
    always_comb begin
        do_load = 1'b0;
        do_step = 1'b0;
        unique case (state_q)
            S_IDLE: do_load = any_pend;
            S_PLAY: begin
                if (tick) begin
                    if (preempt) begin
                        do_load = 1'b1;
                    end else begin
                        do_step = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        step_end  = do_step && (step_cnt_q == SW'(STEP_TICKS - 1));
        last_step = step_end && (steps_left_q == 4'd1);
        load_oh   = do_load ? win_oh : '0;
    end

    // Datapath and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q       <= '0;
            presc_q      <= '0;
            step_cnt_q   <= '0;
            steps_left_q <= '0;
            note_q       <= '0;
            delta_q      <= '0;
            active_id_q  <= '0;
            grant_q      <= '0;
            done_q       <= 1'b0;
        end else begin
            // A request arriving in the grant cycle re-arms the latch.
            pend_q  <= (pend_q & ~load_oh) | bus.req;
            grant_q <= load_oh;
            done_q  <= last_step;

            // Restarting the prescaler on load aligns step boundaries to
            // the load edge.
            if (do_load || tick) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + PW'(1);
            end

            if (do_load) begin
                active_id_q  <= win;
                steps_left_q <= (sel_len == 4'd0) ? 4'd1 : sel_len;
                step_cnt_q   <= '0;
                note_q       <= sel_base;
                delta_q      <= sel_delta;
            end else if (step_end) begin
                step_cnt_q <= '0;
                if (last_step) begin
                    note_q <= '0;
                end else begin
                    steps_left_q <= steps_left_q - 4'd1;
                    note_q       <= note_step(note_q, delta_q);
                end
            end else if (do_step) begin
                step_cnt_q <= step_cnt_q + SW'(1);
            end
        end
    end

    // Mute sits after the register so it acts within the same cycle and
    // leaves the sequencing state untouched.
    assign bus.note      = bus.mute ? 6'd0 : note_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.active_id = active_id_q;
    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_sfx_sequencer.sv
// Testbench for sfx_sequencer with TICK_DIV=4, STEP_TICKS=2 (8 cycles/step).
module tb_sfx_sequencer;
    localparam int N  = 4;
    localparam int TD = 4;
    localparam int ST = 2;
    localparam int SC = TD * ST;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sfx_sequencer_if #(.N_REQ(N)) bus ();

    sfx_sequencer #(.N_REQ(N), .TICK_DIV(TD), .STEP_TICKS(ST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model (time-based) ----------------
    // m_state: 0 idle, 1 play, 2 gap. m_t counts cycles since the load edge;
    // ticks fall on multiples of TD, step k covers m_t in [k*SC, (k+1)*SC).
    int           m_state, m_t, m_id, m_base, m_len, m_delta;
    logic [N-1:0] m_pend, m_grant;
    bit           m_done;

    function automatic int note_after(int base, int d, int k);
        int n;
        n = base;
        for (int s = 0; s < k; s++) begin
            if (n != 0) begin
                n = n + d;
                if (n < 1)  n = 1;
                if (n > 63) n = 63;
            end
        end
        return n;
    endfunction

    task automatic model_reset();
        m_state = 0; m_t = 0; m_id = 0; m_base = 0; m_len = 1; m_delta = 0;
        m_pend = '0; m_grant = '0; m_done = 0;
    endtask

    task automatic model_step();
        logic [N-1:0]      p;
        int                w;
        bit                load;
        logic signed [2:0] ds;
        p = m_pend;
        w = -1;
        for (int i = N - 1; i >= 0; i--) if (p[i]) w = i;
        load = 0; m_grant = '0; m_done = 0;
        if (m_state != 0) m_t++;
        case (m_state)
            0: load = (w >= 0);
            1: begin
                if ((m_t % TD) == 0 && w >= 0 && w < m_id) load = 1;
                else if (m_t == m_len * SC) begin
                    m_done = 1; m_state = 2;
                end
            end
            default: if (m_t == m_len * SC + TD) m_state = 0;
        endcase
        if (load) begin
            m_state = 1; m_t = 0; m_id = w;
            m_base  = int'(bus.req_base[w*6 +: 6]);
            m_len   = int'(bus.req_len[w*4 +: 4]);
            if (m_len == 0) m_len = 1;
            ds      = bus.req_delta[w*3 +: 3];
            m_delta = ds;
            m_grant[w] = 1'b1;
            p[w] = 1'b0;
        end
        m_pend = p | bus.req;
    endtask

    task automatic model_check();
        int en;
        en = (m_state == 1) ? note_after(m_base, m_delta, m_t / SC) : 0;
        if (bus.mute) en = 0;
        chk("model_note",      int'(bus.note),      en);
        chk("model_busy",      int'(bus.busy),      (m_state != 0) ? 1 : 0);
        chk("model_active_id", int'(bus.active_id), m_id);
        chk("model_grant",     int'(bus.grant),     int'(m_grant));
        chk("model_done",      int'(bus.done),      int'(m_done));
    endtask

    // One clock: model follows the edge, outputs compared at the falling edge.
    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        @(negedge clk);
        model_check();
    endtask

    task automatic set_eff(int id, int base, int len, int delta);
        bus.req_base[id*6 +: 6]  = 6'(base);
        bus.req_len[id*4 +: 4]   = 4'(len);
        bus.req_delta[id*3 +: 3] = 3'(delta);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int id; int base; int len; int delta; int steps;
        int n0; int n1; int n2;
    } vec_t;
    vec_t tbl[6];

    function automatic int pick(vec_t v, int s);
        if (s == 0) return v.n0;
        if (s == 1) return v.n1;
        return v.n2;
    endfunction

    int en, tot, g0_at, g1_at, g3_at, g2n, dn, first_dn, note_k5, done_at;

    initial begin
        tbl[0] = '{2, 24, 3,  2, 3, 24, 26, 28};
        tbl[1] = '{1, 62, 3,  3, 3, 62, 63, 63};
        tbl[2] = '{3,  2, 3, -4, 3,  2,  1,  1};
        tbl[3] = '{0, 10, 0,  1, 1, 10,  0,  0};
        tbl[4] = '{2,  0, 2,  3, 2,  0,  0,  0};
        tbl[5] = '{1,  5, 2, -1, 2,  5,  4,  0};

        rst_n = 1'b0;
        bus.req = '0; bus.req_base = '0; bus.req_len = '0; bus.req_delta = '0;
        bus.mute = 1'b0;
        model_reset();
        step();
        step();
        chk("reset_note",   int'(bus.note), 0);
        chk("reset_busy",   int'(bus.busy), 0);
        chk("reset_grant",  int'(bus.grant), 0);
        chk("reset_done",   int'(bus.done), 0);
        chk("reset_active", int'(bus.active_id), 0);
        rst_n = 1'b1;
        step();

        // Table-driven single effects (timing measured from the request edge)
        for (int r = 0; r < 6; r++) begin
            set_eff(tbl[r].id, tbl[r].base, tbl[r].len, tbl[r].delta);
            bus.req = 4'(1 << tbl[r].id);
            step();
            bus.req = '0;
            tot = tbl[r].steps * SC + 5;
            for (int k = 1; k <= tot; k++) begin
                step();
                en = (k <= tbl[r].steps * SC) ? pick(tbl[r], (k - 1) / SC) : 0;
                chk("vec_note",  int'(bus.note),  en);
                chk("vec_grant", int'(bus.grant), (k == 1) ? (1 << tbl[r].id) : 0);
                chk("vec_done",  int'(bus.done),  (k == tbl[r].steps * SC + 1) ? 1 : 0);
                chk("vec_busy",  int'(bus.busy),  (k <= tbl[r].steps * SC + 4) ? 1 : 0);
            end
        end

        // Simultaneous requests 1 and 3
        set_eff(1, 20, 1, 1);
        set_eff(3, 30, 1, 1);
        bus.req = 4'b1010;
        step();
        bus.req = '0;
        g1_at = -1; g3_at = -1; dn = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (bus.grant[1] && g1_at < 0) g1_at = k;
            if (bus.grant[3] && g3_at < 0) g3_at = k;
            if (bus.done) dn++;
        end
        chk("simul_grant1_cycle", g1_at, 1);
        chk("simul_grant3_cycle", g3_at, 14);
        chk("simul_done_count",   dn, 2);

        // Preemption by requester 0
        set_eff(2, 24, 3, 2);
        set_eff(0, 40, 1, 0);
        bus.req = 4'b0100;
        step();
        bus.req = '0;
        g0_at = -1; g2n = 0; dn = 0; note_k5 = -1;
        for (int k = 1; k <= 40; k++) begin
            bus.req = (k == 4) ? 4'b0001 : 4'b0000;
            step();
            if (bus.grant[0] && g0_at < 0) g0_at = k;
            if (bus.grant[2]) g2n++;
            if (bus.done) dn++;
            if (k == 5) note_k5 = int'(bus.note);
        end
        bus.req = '0;
        chk("preempt_grant0_cycle", g0_at, 5);
        chk("preempt_note_after",   note_k5, 40);
        chk("preempt_grant2_count", g2n, 1);
        chk("preempt_done_count",   dn, 1);

        // Lower-priority request waits
        set_eff(3, 50, 1, 0);
        bus.req = 4'b0100;
        step();
        g3_at = -1; dn = 0; first_dn = -1;
        for (int k = 1; k <= 45; k++) begin
            bus.req = (k == 4) ? 4'b1000 : 4'b0000;
            step();
            if (bus.grant[3] && g3_at < 0) g3_at = k;
            if (bus.done) begin
                dn++;
                if (first_dn < 0) first_dn = k;
            end
        end
        bus.req = '0;
        chk("nopreempt_first_done", first_dn, 25);
        chk("nopreempt_grant3",     g3_at, 30);
        chk("nopreempt_done_count", dn, 2);

        // Mute mid-effect
        set_eff(1, 30, 2, 1);
        bus.req = 4'b0010;
        step();
        bus.req = '0;
        for (int k = 1; k <= 3; k++) step();
        bus.mute = 1'b1;
        #1;
        chk("mute_same_cycle", int'(bus.note), 0);
        chk("mute_busy",       int'(bus.busy), 1);
        done_at = -1;
        for (int k = 4; k <= 21; k++) begin
            step();
            if (bus.done && done_at < 0) done_at = k;
        end
        bus.mute = 1'b0;
        chk("mute_done_cycle", done_at, 17);

        // Reset mid-play with a request pending
        set_eff(2, 24, 3, 2);
        bus.req = 4'b0100;
        step();
        bus.req = '0;
        for (int k = 1; k <= 5; k++) begin
            bus.req = (k == 2) ? 4'b1000 : 4'b0000;
            step();
        end
        bus.req = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_note",   int'(bus.note), 0);
        chk("rstmid_busy",   int'(bus.busy), 0);
        chk("rstmid_active", int'(bus.active_id), 0);
        chk("rstmid_grant",  int'(bus.grant), 0);
        chk("rstmid_done",   int'(bus.done), 0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) step();
        chk("rstmid_pending_lost", int'(bus.busy), 0);

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            bus.req       = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
            bus.req_base  = 24'($urandom);
            bus.req_len   = 16'($urandom);
            bus.req_delta = 12'($urandom);
            bus.mute      = ($urandom_range(0, 15) == 0);
            step();
        end
        bus.req  = '0;
        bus.mute = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
